// File: rtl/pool_stream_mc.sv
// pool_stream_mc: multi-channel POOLxPOOL, stride-POOL pooling (max or average)
// over a raster-ordered stream of packed CH-channel signed activations.
// Horizontal partial results live in a per-channel accumulator. Vertical
// partial results live in a line buffer with one entry per output column.
// Each output column's entry is prefetched at the first beat of its window,
// so the buffer read is registered and still ready in time.
module pool_stream_mc #(
  parameter int DATA_W = 16,
  parameter int CH     = 2,
  parameter int IMG_W  = 24,
  parameter int IMG_H  = 24,
  parameter int POOL   = 2
) (
  input  logic                 sclk,
  input  logic                 s_rst_n,
  input  logic                 cal_start,
  input  logic                 mode,
  input  logic [CH*DATA_W-1:0] act_data,
  input  logic                 act_data_vld,
  output logic [CH*DATA_W-1:0] pool_data,
  output logic                 pool_data_vld,
  output logic                 pool_row_end,
  output logic                 frame_done,
  output logic                 drop_err
);

  // log2 of the window size; an average divides by POOL*POOL = 2^(2*LP)
  localparam int LP  = $clog2(POOL);
  // accumulator width: enough headroom for a full-window signed sum
  localparam int AW  = DATA_W + 2 * LP;
  // number of output columns (line buffer depth)
  localparam int OW  = IMG_W / POOL;
  localparam int CW  = $clog2(IMG_W);
  localparam int RW  = $clog2(IMG_H);
  localparam int OCW = CW - LP;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_reg, state_next;

  logic [CW-1:0]  col_reg;
  logic [RW-1:0]  row_reg;
  logic           mode_reg;

  // counters and mode as seen by the current beat: a coincident cal_start
  // makes this beat pixel (0,0) of a new frame in the newly sampled mode
  logic [CW-1:0]  col_eff;
  logic [RW-1:0]  row_eff;
  logic           mode_eff;

  logic [LP-1:0]  wc;
  logic [LP-1:0]  wr;
  logic [OCW-1:0] oc;

  logic beat_ok;
  logic beat_drop;
  logic last_beat;
  logic win_h_end;
  logic win_v_end;
  logic win_done;

  logic [CH*AW-1:0]     h_acc_reg;
  logic [CH*AW-1:0]     h_acc_next;
  logic [CH*AW-1:0]     rd_reg;
  logic [CH*AW-1:0]     v_val;
  logic [CH*DATA_W-1:0] res_val;

  logic [CH*AW-1:0] lb_mem [0:OW-1];

  logic [CH*DATA_W-1:0] pool_data_reg;
  logic                 pool_vld_reg;
  logic                 row_end_reg;
  logic                 done_pend_reg;
  logic                 frame_done_reg;
  logic                 drop_err_reg;

  // per-channel combine: signed sum for average, signed maximum for max
  function automatic logic [AW-1:0] combine(input logic [AW-1:0] a,
                                            input logic [AW-1:0] b,
                                            input logic          avg);
    logic [AW-1:0] r;
    if (avg) begin
      r = a + b;
    end else begin
      r = ($signed(a) > $signed(b)) ? a : b;
    end
    return r;
  endfunction

  assign col_eff  = cal_start ? '0 : col_reg;
  assign row_eff  = cal_start ? '0 : row_reg;
  assign mode_eff = cal_start ? mode : mode_reg;

  assign wc = col_eff[LP-1:0];
  assign wr = row_eff[LP-1:0];
  assign oc = col_eff[CW-1:LP];

  // beats are accepted while running, or when they open a new frame
  assign beat_ok   = act_data_vld && (cal_start || (state_reg == RUN));
  assign beat_drop = act_data_vld && !cal_start && (state_reg != RUN);
  assign last_beat = (col_eff == CW'(IMG_W - 1)) && (row_eff == RW'(IMG_H - 1));
  assign win_h_end = (wc == LP'(POOL - 1));
  assign win_v_end = (wr == LP'(POOL - 1));
  assign win_done  = beat_ok && win_h_end && win_v_end;

  // per-channel horizontal and vertical combine datapath
  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
      logic [AW-1:0] in_ext;
      logic [AW-1:0] hr;

      assign in_ext = {{(2 * LP){act_data[gi*DATA_W+DATA_W-1]}},
                       act_data[gi*DATA_W +: DATA_W]};
      assign hr = combine(h_acc_reg[gi*AW +: AW], in_ext, mode_eff);
      assign h_acc_next[gi*AW +: AW] = (wc == '0) ? in_ext : hr;
      assign v_val[gi*AW +: AW] = (wr == '0) ? hr
                                : combine(rd_reg[gi*AW +: AW], hr, mode_eff);
      // arithmetic right shift floors the average toward negative infinity
      assign res_val[gi*DATA_W +: DATA_W] =
        mode_eff ? DATA_W'($signed(v_val[gi*AW +: AW]) >>> (2 * LP))
                 : DATA_W'(v_val[gi*AW +: AW]);
    end
  endgenerate

  // frame state register
  always_ff @(posedge sclk) begin
    if (!s_rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // frame state transitions: cal_start always (re)starts, last beat finishes
  always_comb begin
    state_next = state_reg;
    if (cal_start) begin
      state_next = RUN;
    end
    if (beat_ok && last_beat) begin
      state_next = DONE;
    end
  end

  // raster counters and the mode latched at frame start
  always_ff @(posedge sclk) begin
    if (!s_rst_n) begin
      col_reg  <= '0;
      row_reg  <= '0;
      mode_reg <= 1'b0;
    end else begin
      if (cal_start) begin
        mode_reg <= mode;
      end
      if (beat_ok) begin
        if (col_eff == CW'(IMG_W - 1)) begin
          col_reg <= '0;
          row_reg <= (row_eff == RW'(IMG_H - 1)) ? '0 : row_eff + RW'(1);
        end else begin
          col_reg <= col_eff + CW'(1);
          row_reg <= row_eff;
        end
      end else if (cal_start) begin
        col_reg <= '0;
        row_reg <= '0;
      end
    end
  end

  // horizontal accumulator, cleared when a new frame starts
  always_ff @(posedge sclk) begin
    if (!s_rst_n) begin
      h_acc_reg <= '0;
    end else if (beat_ok) begin
      h_acc_reg <= h_acc_next;
    end else if (cal_start) begin
      h_acc_reg <= '0;
    end
  end

  // line buffer: prefetch at window start, write back at horizontal window end
  always_ff @(posedge sclk) begin
    if (beat_ok && (wc == '0)) begin
      rd_reg <= lb_mem[oc];
    end
    if (beat_ok && win_h_end && !win_v_end) begin
      lb_mem[oc] <= v_val;
    end
  end

  // output registers and strobes
  always_ff @(posedge sclk) begin
    if (!s_rst_n) begin
      pool_data_reg  <= '0;
      pool_vld_reg   <= 1'b0;
      row_end_reg    <= 1'b0;
      done_pend_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
      drop_err_reg   <= 1'b0;
    end else begin
      pool_vld_reg   <= win_done;
      row_end_reg    <= win_done && (oc == OCW'(OW - 1));
      if (win_done) begin
        pool_data_reg <= res_val;
      end
      done_pend_reg  <= beat_ok && last_beat;
      frame_done_reg <= done_pend_reg;
      drop_err_reg   <= beat_drop;
    end
  end

  assign pool_data     = pool_data_reg;
  assign pool_data_vld = pool_vld_reg;
  assign pool_row_end  = row_end_reg;
  assign frame_done    = frame_done_reg;
  assign drop_err      = drop_err_reg;

endmodule

// File: tb/tb_pool_stream_mc.sv
// tb_pool_stream_mc: directed, table-driven check of pool_stream_mc on an
// 8x8, 2-channel, 2x2 configuration.
module tb_pool_stream_mc;

  localparam int DW = 16;
  localparam int CH = 2;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int P  = 2;

  logic              sclk = 1'b0;
  logic              s_rst_n = 1'b0;
  logic              cal_start = 1'b0;
  logic              mode = 1'b0;
  logic [CH*DW-1:0]  act_data = '0;
  logic              act_data_vld = 1'b0;
  logic [CH*DW-1:0]  pool_data;
  logic              pool_data_vld;
  logic              pool_row_end;
  logic              frame_done;
  logic              drop_err;

  pool_stream_mc #(
    .DATA_W(DW), .CH(CH), .IMG_W(W), .IMG_H(H), .POOL(P)
  ) dut (
    .sclk(sclk),
    .s_rst_n(s_rst_n),
    .cal_start(cal_start),
    .mode(mode),
    .act_data(act_data),
    .act_data_vld(act_data_vld),
    .pool_data(pool_data),
    .pool_data_vld(pool_data_vld),
    .pool_row_end(pool_row_end),
    .frame_done(frame_done),
    .drop_err(drop_err)
  );

  always #5 sclk = ~sclk;

  typedef struct {
    logic signed [15:0] d0;
    logic signed [15:0] d1;
    bit                 re;
  } out_t;

  // expected result per output window: window coordinates and results
  typedef struct {
    int                 orow;
    int                 ocol;
    logic signed [15:0] mx0;
    logic signed [15:0] mx1;
    logic signed [15:0] av0;
    logic signed [15:0] av1;
    bit                 re;
  } vec_t;

  // full-frame scenarios: mode, data pattern, max gap, coincident start, toggle beat
  typedef struct {
    string nm;
    bit    md;
    int    pat;
    int    gap;
    bit    coinc;
    int    tog;
  } scen_t;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   timing_err = 0;
  int   fd_cnt = 0;
  int   fd_cyc = -1;
  int   drop_cnt = 0;
  out_t outq[$];
  vec_t tbl[16];
  scen_t scen[6];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // drive one cycle, then sample outputs 1ns after the rising edge
  task automatic tick(input bit v, input logic signed [15:0] d0,
                      input logic signed [15:0] d1, input bit cs, input bit exp_v);
    out_t o;
    act_data_vld = v;
    act_data     = {d1, d0};
    cal_start    = cs;
    @(posedge sclk);
    #1;
    cyc++;
    act_data_vld = 1'b0;
    cal_start    = 1'b0;
    if (pool_data_vld !== exp_v) timing_err++;
    if (pool_data_vld === 1'b1) begin
      o.d0 = pool_data[15:0];
      o.d1 = pool_data[31:16];
      o.re = pool_row_end;
      outq.push_back(o);
    end
    if (frame_done === 1'b1) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
    if (drop_err === 1'b1) drop_cnt++;
  endtask

  task automatic send_frame(input bit md, input int pat, input int gap, input bit coinc,
                            input int tog, input int nbeats, output int last_cyc);
    logic signed [15:0] d0;
    int r;
    int c;
    outq.delete();
    timing_err = 0;
    fd_cnt     = 0;
    fd_cyc     = -1;
    drop_cnt   = 0;
    mode       = md;
    last_cyc   = cyc;
    if (!coinc) tick(1'b0, 16'sd0, 16'sd0, 1'b1, 1'b0);
    for (int i = 0; i < nbeats; i++) begin
      r = i / W;
      c = i % W;
      if (pat == 0) d0 = 16'(r * W + c);
      else          d0 = 16'(1 + (c % 2) + 2 * (r % 2));
      if (i == tog) mode = 1'b1;
      if (i > 0 && gap > 0) begin
        repeat ($urandom_range(gap, 0)) tick(1'b0, 16'sd0, 16'sd0, 1'b0, 1'b0);
      end
      tick(1'b1, d0, -d0, coinc && (i == 0), (c % 2 == 1) && (r % 2 == 1));
      last_cyc = cyc;
    end
  endtask

  task automatic check_frame(input string nm, input bit avg, input int last_cyc);
    repeat (3) tick(1'b0, 16'sd0, 16'sd0, 1'b0, 1'b0);
    chk({nm, " output count"}, outq.size(), 16);
    for (int k = 0; k < outq.size() && k < 16; k++) begin
      chk($sformatf("%s out%0d ch0", nm, k), int'(outq[k].d0),
          avg ? int'(tbl[k].av0) : int'(tbl[k].mx0));
      chk($sformatf("%s out%0d ch1", nm, k), int'(outq[k].d1),
          avg ? int'(tbl[k].av1) : int'(tbl[k].mx1));
      chk($sformatf("%s out%0d row_end", nm, k), int'(outq[k].re), int'(tbl[k].re));
    end
    chk({nm, " valid timing errors"}, timing_err, 0);
    chk({nm, " frame_done count"}, fd_cnt, 1);
    chk({nm, " frame_done cycle"}, fd_cyc, last_cyc + 1);
    chk({nm, " drop_err count"}, drop_cnt, 0);
  endtask

  initial begin
    int lc;

    for (int k = 0; k < 16; k++) begin
      tbl[k].orow = k / 4;
      tbl[k].ocol = k % 4;
      tbl[k].mx0  = 16'((2 * tbl[k].orow + 1) * W + 2 * tbl[k].ocol + 1);
      tbl[k].mx1  = 16'(-(2 * tbl[k].orow * W + 2 * tbl[k].ocol));
      tbl[k].av0  = 16'sd2;
      tbl[k].av1  = -16'sd3;
      tbl[k].re   = (tbl[k].ocol == 3);
    end
    scen[0] = '{"max_ramp",   1'b0, 0, 0, 1'b0, -1};
    scen[1] = '{"avg_floor",  1'b1, 1, 0, 1'b0, -1};
    scen[2] = '{"gapped",     1'b0, 0, 5, 1'b0, -1};
    scen[3] = '{"coincident", 1'b0, 0, 0, 1'b1, -1};
    scen[4] = '{"mode_lock",  1'b0, 0, 0, 1'b0, 10};
    scen[5] = '{"avg_next",   1'b1, 1, 0, 1'b0, -1};

    // reset state
    tick(1'b0, 16'sd0, 16'sd0, 1'b0, 1'b0);
    tick(1'b0, 16'sd0, 16'sd0, 1'b0, 1'b0);
    chk("reset pool_data", int'(pool_data), 0);
    chk("reset pool_data_vld", int'(pool_data_vld), 0);
    chk("reset pool_row_end", int'(pool_row_end), 0);
    chk("reset frame_done", int'(frame_done), 0);
    chk("reset drop_err", int'(drop_err), 0);
    s_rst_n = 1'b1;
    tick(1'b0, 16'sd0, 16'sd0, 1'b0, 1'b0);

    // table of complete frames
    for (int s = 0; s < 6; s++) begin
      send_frame(scen[s].md, scen[s].pat, scen[s].gap, scen[s].coinc, scen[s].tog, 64, lc);
      check_frame(scen[s].nm, scen[s].md, lc);
      $display("frame %s: %0d outputs", scen[s].nm, outq.size());
    end

    // beat after the final pixel is dropped, then a fresh frame pools
    outq.delete();
    timing_err = 0;
    drop_cnt = 0;
    tick(1'b1, 16'sd5, -16'sd5, 1'b0, 1'b0);
    tick(1'b0, 16'sd0, 16'sd0, 1'b0, 1'b0);
    chk("drop after frame drop_err count", drop_cnt, 1);
    chk("drop after frame outputs", outq.size(), 0);
    chk("drop after frame valid timing", timing_err, 0);
    $display("drop after frame: drop_err pulses=%0d", drop_cnt);
    send_frame(1'b0, 0, 0, 1'b0, -1, 64, lc);
    check_frame("after_drop", 1'b0, lc);

    // restart after 20 beats
    send_frame(1'b0, 0, 0, 1'b0, -1, 20, lc);
    send_frame(1'b0, 0, 0, 1'b0, -1, 64, lc);
    check_frame("restart", 1'b0, lc);
    $display("restart after 20 beats: %0d outputs", outq.size());

    // reset pulse after 30 beats; the last of them completes a window
    send_frame(1'b0, 0, 0, 1'b0, -1, 30, lc);
    chk("pre-reset valid timing", timing_err, 0);
    timing_err = 0;
    s_rst_n = 1'b0;
    tick(1'b0, 16'sd0, 16'sd0, 1'b0, 1'b0);
    s_rst_n = 1'b1;
    chk("mid reset pool_data", int'(pool_data), 0);
    chk("mid reset pool_data_vld", int'(pool_data_vld), 0);
    chk("mid reset pool_row_end", int'(pool_row_end), 0);
    drop_cnt = 0;
    tick(1'b1, 16'sd7, -16'sd7, 1'b0, 1'b0);
    tick(1'b0, 16'sd0, 16'sd0, 1'b0, 1'b0);
    chk("post reset idle drop count", drop_cnt, 1);
    chk("post reset valid timing", timing_err, 0);
    $display("mid-frame reset: idle drop pulses=%0d", drop_cnt);
    send_frame(1'b0, 0, 0, 1'b0, -1, 64, lc);
    check_frame("after_reset", 1'b0, lc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
